// File: rtl/phivers_link_fifo.sv
// Buffered Phivers NoC inter-router link: registered FWFT FIFO with packet tracking,
// saturating traffic counters and a sticky credit-starvation alarm.
module phivers_link_fifo #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     tx_i,
  output logic                     cr_tx_o,
  input  logic                     eop_tx_i,
  input  logic [FLIT_WIDTH-1:0]    data_tx_i,
  output logic                     rx_o,
  input  logic                     cr_rx_i,
  output logic                     eop_rx_o,
  output logic [FLIT_WIDTH-1:0]    data_rx_o,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     in_pkt_o,
  output logic                     stall_alarm_o,
  output logic [CNT_WIDTH-1:0]     flit_cnt_o,
  output logic [CNT_WIDTH-1:0]     pkt_cnt_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  localparam logic [LVL_W-1:0]   FULL_LVL   = LVL_W'(DEPTH);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  typedef enum logic {PKT_IDLE, PKT_BODY} pkt_state_t;
  typedef enum logic {MONITOR, ALARM}     mon_state_t;

  logic [FLIT_WIDTH:0]  mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     count;
  logic [STALL_W-1:0]   stall_cnt;
  logic [CNT_WIDTH-1:0] flit_cnt;
  logic [CNT_WIDTH-1:0] pkt_cnt;

  pkt_state_t pkt_state, pkt_next;
  mon_state_t mon_state, mon_next;

  logic push;
  logic pop;
  logic stall;
  logic not_empty;
  logic head_eop;
  logic [FLIT_WIDTH-1:0] head_data;

  // Credit depends only on registered occupancy, flush and reset, never on cr_rx_i/tx_i.
  assign cr_tx_o   = rst_ni & (count != FULL_LVL) & ~flush_i;
  assign not_empty = (count != '0);
  assign push      = tx_i & cr_tx_o;
  assign pop       = not_empty & cr_rx_i;
  assign stall     = not_empty & ~cr_rx_i;

  assign head_eop  = mem[rd_ptr][FLIT_WIDTH];
  assign head_data = mem[rd_ptr][FLIT_WIDTH-1:0];

  assign rx_o       = not_empty;
  assign eop_rx_o   = not_empty & head_eop;
  assign data_rx_o  = not_empty ? head_data : '0;
  assign level_o    = count;
  assign flit_cnt_o = flit_cnt;
  assign pkt_cnt_o  = pkt_cnt;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {eop_tx_i, data_tx_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flit_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (push) begin
      if (flit_cnt != '1) begin
        flit_cnt <= flit_cnt + CNT_WIDTH'(1);
      end
      if (eop_tx_i && pkt_cnt != '1) begin
        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_state <= PKT_IDLE;
    end else begin
      pkt_state <= pkt_next;
    end
  end

  always_comb begin
    pkt_next = pkt_state;
    if (flush_i) begin
      pkt_next = PKT_IDLE;
    end else if (pop) begin
      pkt_next = head_eop ? PKT_IDLE : PKT_BODY;
    end
  end

  always_comb begin
    in_pkt_o = (pkt_state == PKT_BODY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mon_state <= MONITOR;
    end else begin
      mon_state <= mon_next;
    end
  end

  // Alarm is entered on the same edge that takes the counter to TIMEOUT.
  always_comb begin
    mon_next = mon_state;
    unique case (mon_state)
      MONITOR: begin
        if (flush_i) begin
          mon_next = MONITOR;
        end else if (stall && stall_cnt == STALL_LAST) begin
          mon_next = ALARM;
        end
      end
      ALARM: begin
        if (flush_i) begin
          mon_next = MONITOR;
        end
      end
      default: mon_next = MONITOR;
    endcase
  end

  always_comb begin
    stall_alarm_o = (mon_state == ALARM);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (flush_i) begin
      stall_cnt <= '0;
    end else if (mon_state == ALARM) begin
      stall_cnt <= stall_cnt;
    end else if (pop || !not_empty) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_phivers_link_fifo.sv
// Directed self-checking bench for phivers_link_fifo (DEPTH 4, TIMEOUT 8, CNT_WIDTH 4).
module tb_phivers_link_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx;
  logic        cr_tx;
  logic        eop_tx;
  logic [31:0] data_tx;
  logic        rx;
  logic        cr_rx;
  logic        eop_rx;
  logic [31:0] data_rx;
  logic        flush;
  logic [2:0]  level;
  logic        in_pkt;
  logic        alarm;
  logic [3:0]  flit_cnt;
  logic [3:0]  pkt_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phivers_link_fifo #(
    .FLIT_WIDTH(32),
    .DEPTH(4),
    .TIMEOUT(8),
    .CNT_WIDTH(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .tx_i(tx),
    .cr_tx_o(cr_tx),
    .eop_tx_i(eop_tx),
    .data_tx_i(data_tx),
    .rx_o(rx),
    .cr_rx_i(cr_rx),
    .eop_rx_o(eop_rx),
    .data_rx_o(data_rx),
    .flush_i(flush),
    .level_o(level),
    .in_pkt_o(in_pkt),
    .stall_alarm_o(alarm),
    .flit_cnt_o(flit_cnt),
    .pkt_cnt_o(pkt_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tx = 0; eop_tx = 0; data_tx = '0; cr_rx = 0; flush = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    checks++; if (rx !== 1'b0)    begin errors++; $display("FAIL reset_rx got %0b exp 0", rx); end
    checks++; if (cr_tx !== 1'b1) begin errors++; $display("FAIL reset_cr_tx got %0b exp 1", cr_tx); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (flit_cnt !== 4'd0 || pkt_cnt !== 4'd0)
      begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", flit_cnt, pkt_cnt); end
    checks++; if (alarm !== 1'b0 || in_pkt !== 1'b0)
      begin errors++; $display("FAIL reset_alarm_inpkt got %0b/%0b exp 0/0", alarm, in_pkt); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp;
    apply_reset();
    cr_rx = 0;
    for (int i = 0; i < 4; i++) begin
      tx = 1; data_tx = 32'hA0 + 32'(i); eop_tx = (i == 3);
      #1;
      checks++; if (cr_tx !== 1'b1) begin errors++; $display("FAIL fill_credit[%0d] got %0b exp 1", i, cr_tx); end
      tick();
      checks++; if (rx !== 1'b1) begin errors++; $display("FAIL fill_rx[%0d] got %0b exp 1", i, rx); end
    end
    tx = 0; eop_tx = 0;
    #1;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", level); end
    checks++; if (cr_tx !== 1'b0) begin errors++; $display("FAIL full_credit got %0b exp 0", cr_tx); end
    cr_rx = 1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'hA0 + 32'(i);
      #1;
      checks++; if (data_rx !== exp) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, data_rx, exp); end
      checks++; if (eop_rx !== (i == 3)) begin errors++; $display("FAIL drain_eop[%0d] got %0b exp %0b", i, eop_rx, (i == 3)); end
      tick();
      if (i == 0) begin
        checks++; if (cr_tx !== 1'b1) begin errors++; $display("FAIL credit_return got %0b exp 1", cr_tx); end
      end
    end
    cr_rx = 0;
    checks++; if (rx !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL drain_empty got rx %0b level %0d exp 0 0", rx, level); end
    checks++; if (flit_cnt !== 4'd4) begin errors++; $display("FAIL fill_flit_cnt got %0d exp 4", flit_cnt); end
    checks++; if (pkt_cnt !== 4'd1) begin errors++; $display("FAIL fill_pkt_cnt got %0d exp 1", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int bad_level = 0;
    int bad_data  = 0;
    apply_reset();
    cr_rx = 0; tx = 1; eop_tx = 0;
    for (int i = 0; i < 2; i++) begin
      data_tx = 32'h100 + 32'(i);
      tick();
    end
    cr_rx = 1;
    for (int i = 0; i < 20; i++) begin
      data_tx = 32'h102 + 32'(i);
      exp = 32'h100 + 32'(i);
      #1;
      if (level !== 3'd2) bad_level++;
      if (data_rx !== exp) bad_data++;
      tick();
    end
    checks++; if (bad_level != 0) begin errors++; $display("FAIL stream_level got %0d bad cycles exp 0", bad_level); end
    checks++; if (bad_data != 0)  begin errors++; $display("FAIL stream_data got %0d bad cycles exp 0", bad_data); end
    tx = 0;
    for (int i = 0; i < 2; i++) begin
      exp = 32'h114 + 32'(i);
      #1;
      checks++; if (data_rx !== exp) begin errors++; $display("FAIL stream_tail[%0d] got %h exp %h", i, data_rx, exp); end
      tick();
    end
    checks++; if (rx !== 1'b0) begin errors++; $display("FAIL stream_empty got %0b exp 0", rx); end
  endtask

  task automatic test_stall_alarm();
    int early = 0;
    apply_reset();
    cr_rx = 0; tx = 1; data_tx = 32'hC0; eop_tx = 1;
    tick();
    tx = 0; eop_tx = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (alarm !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL alarm_early got %0d cycles high exp 0", early); end
    tick();
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_at_8 got %0b exp 1", alarm); end
    cr_rx = 1;
    tick();
    checks++; if (rx !== 1'b0) begin errors++; $display("FAIL alarm_drain got rx %0b exp 0", rx); end
    tick();
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_sticky got %0b exp 1", alarm); end
    flush = 1;
    tick();
    flush = 0; cr_rx = 0;
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_flush got %0b exp 0", alarm); end
  endtask

  task automatic test_flush();
    apply_reset();
    cr_rx = 0;
    for (int i = 0; i < 3; i++) begin
      tx = 1; data_tx = 32'hD0 + 32'(i); eop_tx = (i == 2);
      tick();
    end
    tx = 0; eop_tx = 0; cr_rx = 1;
    tick();
    cr_rx = 0;
    checks++; if (in_pkt !== 1'b1) begin errors++; $display("FAIL flush_in_pkt_before got %0b exp 1", in_pkt); end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL flush_level_before got %0d exp 2", level); end
    flush = 1; tx = 1; data_tx = 32'hDEAD;
    #1;
    checks++; if (cr_tx !== 1'b0) begin errors++; $display("FAIL flush_credit got %0b exp 0", cr_tx); end
    tick();
    flush = 0; tx = 0;
    checks++; if (level !== 3'd0 || rx !== 1'b0) begin errors++; $display("FAIL flush_level got %0d rx %0b exp 0 0", level, rx); end
    checks++; if (in_pkt !== 1'b0) begin errors++; $display("FAIL flush_in_pkt got %0b exp 0", in_pkt); end
    checks++; if (flit_cnt !== 4'd3) begin errors++; $display("FAIL flush_flit_cnt got %0d exp 3", flit_cnt); end
    tick();
    checks++; if (rx !== 1'b0) begin errors++; $display("FAIL flush_dropped got rx %0b exp 0", rx); end
  endtask

  task automatic test_saturate_reset();
    apply_reset();
    cr_rx = 1;
    for (int i = 0; i < 20; i++) begin
      tx = 1; data_tx = 32'hE0 + 32'(i); eop_tx = ((i % 5) == 4);
      tick();
    end
    tx = 0; eop_tx = 0;
    checks++; if (flit_cnt !== 4'd15) begin errors++; $display("FAIL sat_flit_cnt got %0d exp 15", flit_cnt); end
    checks++; if (pkt_cnt !== 4'd4) begin errors++; $display("FAIL sat_pkt_cnt got %0d exp 4", pkt_cnt); end
    tick();
    tx = 1; eop_tx = 0; data_tx = 32'hF0;
    tick();
    data_tx = 32'hF1;
    tick();
    checks++; if (in_pkt !== 1'b1) begin errors++; $display("FAIL mid_pkt got %0b exp 1", in_pkt); end
    #2;
    tx = 0;
    rst_n = 0;
    #1;
    checks++; if (rx !== 1'b0 || cr_tx !== 1'b0 || level !== 3'd0 || data_rx !== 32'd0 || eop_rx !== 1'b0)
      begin errors++; $display("FAIL async_rst_fifo got rx %0b cr %0b lvl %0d data %h eop %0b exp 0", rx, cr_tx, level, data_rx, eop_rx); end
    checks++; if (in_pkt !== 1'b0 || alarm !== 1'b0 || flit_cnt !== 4'd0 || pkt_cnt !== 4'd0)
      begin errors++; $display("FAIL async_rst_state got inpkt %0b alarm %0b cnt %0d/%0d exp 0", in_pkt, alarm, flit_cnt, pkt_cnt); end
    @(negedge clk);
    rst_n = 1;
    tick();
    tick();
    checks++; if (rx !== 1'b0 || cr_tx !== 1'b1) begin errors++; $display("FAIL post_rst got rx %0b cr %0b exp 0 1", rx, cr_tx); end
  endtask

  initial begin
    rst_n = 1; tx = 0; eop_tx = 0; data_tx = '0; cr_rx = 0; flush = 0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_stall_alarm();
    test_flush();
    test_saturate_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
